// File: rtl/alu_seq.sv
// Sequential handshaked ALU: single-cycle logic/arith ops, iterative signed multiply,
// registered result and {overflow, negative, zero} flags behind valid/ready ports.
module alu_seq #(
  parameter int unsigned BW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic [3:0]    opcode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out,
  output logic [2:0]    flags
);

  localparam int unsigned SHW = $clog2(BW);
  localparam int unsigned PW  = 2 * BW;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_INC  = 4'd5;
  localparam logic [3:0] OP_PASA = 4'd6;
  localparam logic [3:0] OP_PASB = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;

  localparam logic [BW-1:0] MAX_POS = {1'b0, {(BW-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic            load_alu, start_mul, load_mul;

  logic [SHW-1:0]  cnt;
  logic [PW-1:0]   acc, mcand;
  logic [BW-1:0]   mplier;
  logic            neg;

  logic [BW-1:0]   alu_res, sum, diff, mag_a, mag_b;
  logic            alu_ovf;
  logic [SHW-1:0]  shamt;
  logic [PW-1:0]   acc_nxt, prod;
  logic            mul_ovf;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake outputs and datapath load strobes
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    load_alu  = 1'b0;
    start_mul = 1'b0;
    load_mul  = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_MUL: begin
        if (cnt == SHW'(BW - 1)) begin
          state_nxt = S_DONE;
          load_mul  = 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    accept = in_valid && in_ready;
    if (accept) begin
      if (opcode == OP_MUL) begin
        start_mul = 1'b1;
        state_nxt = S_MUL;
      end else begin
        load_alu  = 1'b1;
        state_nxt = S_DONE;
      end
    end
  end

  // Single-cycle ops, evaluated on the operands being accepted
  always_comb begin
    sum     = in_a + in_b;
    diff    = in_a - in_b;
    shamt   = in_b[SHW-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (in_a[BW-1] == in_b[BW-1]) && (sum[BW-1] != in_a[BW-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (in_a[BW-1] != in_b[BW-1]) && (diff[BW-1] != in_a[BW-1]);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_INC: begin
        alu_res = in_a + BW'(1);
        alu_ovf = (in_a == MAX_POS);
      end
      OP_PASA: alu_res = in_a;
      OP_PASB: alu_res = in_b;
      OP_SHL:  alu_res = in_a << shamt;
      OP_SHR:  alu_res = BW'($signed(in_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Multiply on magnitudes so -2^(BW-1) stays exact; sign is restored on the full product
  always_comb begin
    mag_a   = in_a[BW-1] ? BW'(-in_a) : in_a;
    mag_b   = in_b[BW-1] ? BW'(-in_b) : in_b;
    acc_nxt = acc + (mplier[0] ? mcand : PW'(0));
    prod    = neg ? PW'(PW'(0) - acc_nxt) : acc_nxt;
    mul_ovf = !((&prod[PW-1:BW-1]) || !(|prod[PW-1:BW-1]));
  end

  // Result registers and shift-add multiplier state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out    <= '0;
      flags  <= 3'b000;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else begin
      if (load_alu) begin
        out   <= alu_res;
        flags <= {alu_ovf, alu_res[BW-1], (alu_res == '0)};
      end else if (load_mul) begin
        out   <= prod[BW-1:0];
        flags <= {mul_ovf, prod[BW-1], (prod[BW-1:0] == '0)};
      end
      if (start_mul) begin
        acc    <= '0;
        mcand  <= PW'(mag_a);
        mplier <= mag_b;
        neg    <= in_a[BW-1] ^ in_b[BW-1];
        cnt    <= '0;
      end else if (state == S_MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + SHW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (BW=16): expected results queued at accept,
// compared when the DUT transfers a result.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic [3:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [2:0]  flags;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [18:0] exp;
    int          acc;
    int          lat;
  } sb_t;
  sb_t sb_q[$];

  alu_seq #(.BW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model using wide signed integer arithmetic
  function automatic logic [18:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    longint sa, sb, full;
    logic [15:0] r;
    logic ovf;
    bit use_full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    full = 0; r = '0; use_full = 0;
    case (op)
      4'd0: begin full = sa + sb; use_full = 1; end
      4'd1: begin full = sa - sb; use_full = 1; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin full = sa + 1; use_full = 1; end
      4'd6: r = a;
      4'd7: r = b;
      4'd8: begin full = sa * sb; use_full = 1; end
      4'd9: r = a << b[3:0];
      4'd10: r = 16'($signed(a) >>> b[3:0]);
      default: r = '0;
    endcase
    if (use_full) r = 16'(full);
    ovf = use_full && ((full > 32767) || (full < -32768));
    return {ovf, r[15], (r == 16'd0), r};
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = sb_q.pop_front();
        check("out", out, e.exp[15:0]);
        check("flags", flags, e.exp[18:16]);
        if (e.lat >= 0) check("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [18:0] exp, input int lat);
    bit got;
    sb_t e;
    got = 0;
    in_valid = 1'b1; opcode = op; in_a = a; in_b = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.exp = exp; e.acc = cyc + 1; e.lat = lat;
        sb_q.push_back(e);
        got = 1;
        break;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    logic [15:0] corner [5];
    logic [15:0] a, b;
    logic [3:0]  op;
    corner[0] = 16'h8000; corner[1] = 16'h7FFF; corner[2] = 16'hFFFF;
    corner[3] = 16'h0000; corner[4] = 16'h0001;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; opcode = '0; out_ready = 1'b1;
    #3;
    check("rst_out", out, 0);
    check("rst_flags", flags, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(4'd0, 16'h7FFF, 16'h0001, {3'b110, 16'h8000}, 0);
    send(4'd8, 16'hFFFD, 16'h0005, {3'b010, 16'hFFF1}, 16);
    low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) break;
      low++;
    end
    check("mul_in_ready_low", low, 16);
    @(posedge clk); #1;
    send(4'd8, 16'h0100, 16'h0100, {3'b101, 16'h0000}, 16);
    send(4'd8, 16'h8000, 16'hFFFF, {3'b110, 16'h8000}, 16);
    send(4'd10, 16'h8000, 16'h0004, {3'b010, 16'hF800}, 0);
    send(4'd9, 16'h0001, 16'h0013, {3'b000, 16'h0008}, 0);
    drain();

    // Backpressure: result must hold while the consumer stalls
    out_ready = 1'b0;
    send(4'd0, 16'h1234, 16'h0001, {3'b000, 16'h1235}, -1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out", out, 16'h1235);
      check("bp_flags", flags, 3'b000);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Back-to-back stream, one result per cycle
    send(4'd0, 16'h0005, 16'hFFFB, {3'b001, 16'h0000}, 0);
    send(4'd0, 16'h8000, 16'h8000, {3'b101, 16'h0000}, 0);
    send(4'd0, 16'h7FFF, 16'h7FFF, {3'b110, 16'hFFFE}, 0);
    send(4'd0, 16'h0001, 16'h0002, {3'b000, 16'h0003}, 0);
    drain();

    // Reset in the middle of a multiply
    send(4'd8, 16'h0002, 16'h0003, {3'b000, 16'h0006}, 16);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("pre_rst_out", out, 16'h0003);
    rst_n = 1'b0;
    #1;
    check("midrst_out", out, 0);
    check("midrst_flags", flags, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    sb_q.delete();
    @(negedge clk);
    check("midrst_hold_valid", out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'd12, 16'h1234, 16'h5678, {3'b001, 16'h0000}, 0);
    drain();

    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      send(op, a, b, model(op, a, b), (op == 4'd8) ? 16 : 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
